// File: rtl/bit_serial_adder.sv
// bit_serial_adder
//   Adds two WIDTH-bit operands one bit per clock, LSB first, through a single
//   full-adder cell with a registered carry. The result and carry-out are
//   registered and announced with a one-cycle done pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin an addition (sampled only while idle)
//   a, b       operands, captured on the accepting edge
//   busy       high while bit steps are in progress
//   done       one-cycle pulse: sum/carry_out hold the new result
//   sum        (a + b) mod 2^WIDTH, held until the next result
//   carry_out  bit WIDTH of a + b, held until the next result
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic [WIDTH-1:0] sum_sr_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             carry_d;
  logic             bit_s;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;
  logic             last_step;

  // Full-adder cell and the sum register's next value. The new bit enters at
  // the MSB so that after WIDTH steps the LSB-first bits sit in place; the
  // shift-then-insert form also covers WIDTH=1 without a zero-width slice.
  always_comb begin
    bit_s               = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_d             = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
    sum_sr_d            = sum_sr_q >> 1;
    sum_sr_d[WIDTH-1]   = bit_s;
    last_step           = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          sum_sr_q <= sum_sr_d;
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_step) begin
            sum_q   <= sum_sr_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: an 8-bit and a 1-bit instance share one clock.
// Expected results are pushed to a per-instance queue when a start is driven
// into an idle DUT, and popped/compared when that DUT raises done.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, cout8;

  // 1-bit instance
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       busy1, done1, cout1;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
  );

  bit_serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
  );

  typedef struct {
    logic [7:0] s;
    logic       c;
    int         due;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Result monitors: compare each done pulse against the scoreboard head,
  // including the cycle on which it was due; a head that goes overdue fails.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) chk("w8 busy&done exclusive", {31'd0, busy8 & done8}, 32'd0);
    if (done8) begin
      if (q8.size() == 0) chk("w8 unexpected done", {31'd0, done8}, 32'd0);
      else begin
        e = q8.pop_front();
        chk("w8 sum", {24'd0, sum8}, {24'd0, e.s});
        chk("w8 carry_out", {31'd0, cout8}, {31'd0, e.c});
        chk("w8 done cycle", cyc, e.due);
      end
    end else if (q8.size() != 0 && cyc > q8[0].due) begin
      chk("w8 done timeout", cyc, q8[0].due);
      void'(q8.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) chk("w1 busy&done exclusive", {31'd0, busy1 & done1}, 32'd0);
    if (done1) begin
      if (q1.size() == 0) chk("w1 unexpected done", {31'd0, done1}, 32'd0);
      else begin
        e = q1.pop_front();
        chk("w1 sum", {31'd0, sum1}, {31'd0, e.s[0]});
        chk("w1 carry_out", {31'd0, cout1}, {31'd0, e.c});
        chk("w1 done cycle", cyc, e.due);
      end
    end else if (q1.size() != 0 && cyc > q1[0].due) begin
      chk("w1 done timeout", cyc, q1[0].due);
      void'(q1.pop_front());
    end
  end

  // Called at a negedge while dut8 is idle: the next posedge accepts.
  task automatic push8(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [8:0] full;
    full  = {1'b0, x} + {1'b0, y};
    e.s   = full[7:0];
    e.c   = full[8];
    e.due = cyc + 1 + 8;
    q8.push_back(e);
  endtask

  task automatic add8(input logic [7:0] x, input logic [7:0] y, input bit expect_done);
    start8 = 1'b1; a8 = x; b8 = y;
    if (expect_done) push8(x, y);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    // Reset
    wait_n(2);
    chk("rst busy8", {31'd0, busy8}, 32'd0);
    chk("rst done8", {31'd0, done8}, 32'd0);
    chk("rst sum8", {24'd0, sum8}, 32'd0);
    chk("rst cout8", {31'd0, cout8}, 32'd0);
    chk("rst busy1", {31'd0, busy1}, 32'd0);
    chk("rst done1", {31'd0, done1}, 32'd0);
    rst = 1'b0;
    wait_n(1);

    // 0x0F + 0x01: busy for eight cycles, done after E8, cleared after E9
    add8(8'h0F, 8'h01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("shift busy", {31'd0, busy8}, 32'd1);
      chk("shift no done", {31'd0, done8}, 32'd0);
      @(negedge clk);
    end
    chk("done pulse", {31'd0, done8}, 32'd1);
    chk("busy low at done", {31'd0, busy8}, 32'd0);
    @(negedge clk);
    chk("done cleared", {31'd0, done8}, 32'd0);
    chk("idle busy", {31'd0, busy8}, 32'd0);

    // 0xFF + 0x01 overflow, result held through idle, then 0xA5 + 0x5A
    add8(8'hFF, 8'h01, 1'b1);
    wait_n(12);
    chk("held sum", {24'd0, sum8}, 32'h00);
    chk("held carry", {31'd0, cout8}, 32'd1);
    add8(8'hA5, 8'h5A, 1'b1);
    wait_n(10);

    // start during SHIFT (sampled at E3) and during DONE (E9) is dropped
    add8(8'h33, 8'h44, 1'b1);
    wait_n(2);
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(negedge clk);
    start8 = 1'b0;
    wait_n(5);
    start8 = 1'b1; a8 = 8'hEE; b8 = 8'hEE;
    @(negedge clk);
    start8 = 1'b0;
    wait_n(2);
    chk("no second add busy", {31'd0, busy8}, 32'd0);
    wait_n(10);
    chk("dropped start sum", {24'd0, sum8}, 32'h77);

    // Reset at E4 aborts 0x80 + 0x80 with no done pulse
    add8(8'h80, 8'h80, 1'b0);
    wait_n(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", {31'd0, busy8}, 32'd0);
    chk("abort done", {31'd0, done8}, 32'd0);
    chk("abort sum", {24'd0, sum8}, 32'd0);
    chk("abort cout", {31'd0, cout8}, 32'd0);
    wait_n(12);
    chk("abort stays idle", {31'd0, busy8}, 32'd0);
    add8(8'h80, 8'h80, 1'b1);
    wait_n(10);

    // start held high: accepts every WIDTH+2 cycles with current operands
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; push8(8'h12, 8'h34);
    wait_n(10);
    a8 = 8'hC8; b8 = 8'h64; push8(8'hC8, 8'h64);
    wait_n(10);
    a8 = 8'h7F; b8 = 8'h81; push8(8'h7F, 8'h81);
    @(negedge clk);
    start8 = 1'b0;
    wait_n(10);

    // WIDTH=1: all four operand combinations, done one cycle after accept
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      start1 = 1'b1;
      a1 = 1'(k >> 1);
      b1 = 1'(k);
      e.s   = {7'd0, a1 ^ b1};
      e.c   = a1[0] & b1[0];
      e.due = cyc + 1 + 1;
      q1.push_back(e);
      @(negedge clk);
      start1 = 1'b0;
      chk("w1 busy", {31'd0, busy1}, 32'd1);
      chk("w1 no early done", {31'd0, done1}, 32'd0);
      @(negedge clk);
      chk("w1 done", {31'd0, done1}, 32'd1);
      @(negedge clk);
    end

    wait_n(3);
    chk("w8 scoreboard drained", q8.size(), 32'd0);
    chk("w1 scoreboard drained", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
